// File: rtl/ctrl_seq.sv
// ctrl_seq -- fetch/decode/execute sequencer for a small accumulator machine.
//
// Each instruction takes FETCH -> DECODE -> EXEC -> FETCH (3 cycles). ALU-mem
// adds a MEMRD cycle after EXEC to cover the 1-cycle data RAM latency. HALT
// is absorbing until reset.
//
// Ports:
//   clk        single clock, all state on the rising edge
//   rst        asynchronous, active-low reset
//   pm_addr    program memory address (the registered PC)
//   pm_data    program word, valid one cycle after pm_addr (synchronous ROM)
//   flag_z/cy/s/o  registered ALU flags, sampled by JCOND in EXEC
//   data_src   ALU operand source: 00 mem, 01 imm, 11 reg
//   immediate  ir[7:0] zero-extended/truncated to WIDTH
//   op         ALU operation ir[10:8]
//   ce_a       accumulator clock-enable
//   ce_cy      carry clock-enable (ce_a qualified by op[2]==0)
//   reg_addr   register index ir[3:0]
//   reg_we     register-file write of the accumulator
//   mem_addr   data address ir[7:0]
//   mem_we     data memory write of the accumulator
//   halted     sticky, set by HALT
//   illegal    sticky, set by an undefined opcode
//   fsm_state  current FSM state (FETCH=0 DECODE=1 EXEC=2 MEMRD=3 HALT=4)
//
// Handshake: there is none; the ROM and RAM are fixed-latency and every
// enable is a single-cycle pulse that the consumer acts on at the next edge.

module ctrl_seq #(
  parameter int WIDTH = 8,
  parameter int PC_W  = 8
) (
  input  logic             clk,
  input  logic             rst,
  output logic [PC_W-1:0]  pm_addr,
  input  logic [15:0]      pm_data,
  input  logic             flag_z,
  input  logic             flag_cy,
  input  logic             flag_s,
  input  logic             flag_o,
  output logic [1:0]       data_src,
  output logic [WIDTH-1:0] immediate,
  output logic [2:0]       op,
  output logic             ce_a,
  output logic             ce_cy,
  output logic [3:0]       reg_addr,
  output logic             reg_we,
  output logic [7:0]       mem_addr,
  output logic             mem_we,
  output logic             halted,
  output logic             illegal,
  output logic [2:0]       fsm_state
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEMRD  = 3'd3,
    S_HALT   = 3'd4
  } state_t;

  localparam logic [3:0] OPC_NOP     = 4'h0;
  localparam logic [3:0] OPC_ALU_IMM = 4'h1;
  localparam logic [3:0] OPC_ALU_REG = 4'h2;
  localparam logic [3:0] OPC_ALU_MEM = 4'h3;
  localparam logic [3:0] OPC_ST_REG  = 4'h4;
  localparam logic [3:0] OPC_ST_MEM  = 4'h5;
  localparam logic [3:0] OPC_JMP     = 4'h6;
  localparam logic [3:0] OPC_JCOND   = 4'h7;
  localparam logic [3:0] OPC_HALT    = 4'hF;

  localparam logic [1:0] DS_MEM = 2'b00;
  localparam logic [1:0] DS_IMM = 2'b01;
  localparam logic [1:0] DS_REG = 2'b11;

  state_t           state;
  logic [PC_W-1:0]  pc;
  logic [15:0]      ir;
  logic [3:0]       ir_opc;
  logic [3:0]       new_opc;
  logic [PC_W-1:0]  jump_target;
  logic             cond_flag;
  logic             cond_taken;

  assign ir_opc      = ir[15:12];
  assign new_opc     = pm_data[15:12];
  assign jump_target = PC_W'(ir[7:0]);

  // Flag select order: 0=Z, 1=CY, 2=S, 3=O; ir[11] inverts the sense.
  always_comb begin
    cond_flag = flag_z;
    case (ir[9:8])
      2'd0:    cond_flag = flag_z;
      2'd1:    cond_flag = flag_cy;
      2'd2:    cond_flag = flag_s;
      default: cond_flag = flag_o;
    endcase
  end

  assign cond_taken = cond_flag ^ ir[11];

  // Enables are registered: they are computed one edge early (from pm_data
  // in DECODE, from ir in EXEC for the MEMRD pulse) so every pulse lines up
  // exactly with its state and reset clears them asynchronously.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= S_FETCH;
      pc      <= '0;
      ir      <= '0;
      halted  <= 1'b0;
      illegal <= 1'b0;
      ce_a    <= 1'b0;
      ce_cy   <= 1'b0;
      reg_we  <= 1'b0;
      mem_we  <= 1'b0;
    end else begin
      case (state)
        S_FETCH: begin
          state  <= S_DECODE;
          ce_a   <= 1'b0;
          ce_cy  <= 1'b0;
          reg_we <= 1'b0;
          mem_we <= 1'b0;
        end

        S_DECODE: begin
          ir     <= pm_data;
          pc     <= pc + PC_W'(1);
          state  <= S_EXEC;
          ce_a   <= (new_opc == OPC_ALU_IMM) || (new_opc == OPC_ALU_REG);
          ce_cy  <= ((new_opc == OPC_ALU_IMM) || (new_opc == OPC_ALU_REG))
                    && !pm_data[10];
          reg_we <= (new_opc == OPC_ST_REG);
          mem_we <= (new_opc == OPC_ST_MEM);
        end

        S_EXEC: begin
          state  <= S_FETCH;
          ce_a   <= 1'b0;
          ce_cy  <= 1'b0;
          reg_we <= 1'b0;
          mem_we <= 1'b0;
          case (ir_opc)
            OPC_NOP, OPC_ALU_IMM, OPC_ALU_REG, OPC_ST_REG, OPC_ST_MEM: begin
              // Work is carried by the enable pulses already issued.
            end
            OPC_ALU_MEM: begin
              // RAM data arrives one cycle after mem_addr is presented.
              state <= S_MEMRD;
              ce_a  <= 1'b1;
              ce_cy <= !ir[10];
            end
            OPC_JMP: pc <= jump_target;
            OPC_JCOND: begin
              if (cond_taken) pc <= jump_target;
            end
            OPC_HALT: begin
              state  <= S_HALT;
              halted <= 1'b1;
            end
            default: illegal <= 1'b1;
          endcase
        end

        S_MEMRD: begin
          state  <= S_FETCH;
          ce_a   <= 1'b0;
          ce_cy  <= 1'b0;
          reg_we <= 1'b0;
          mem_we <= 1'b0;
        end

        S_HALT: begin
          state  <= S_HALT;
          ce_a   <= 1'b0;
          ce_cy  <= 1'b0;
          reg_we <= 1'b0;
          mem_we <= 1'b0;
        end

        default: begin
          state  <= S_FETCH;
          ce_a   <= 1'b0;
          ce_cy  <= 1'b0;
          reg_we <= 1'b0;
          mem_we <= 1'b0;
        end
      endcase
    end
  end

  // Operand source only matters while the accumulator is enabled; it is
  // held at memory otherwise so MEMRD needs no special case.
  always_comb begin
    data_src = DS_MEM;
    if (state == S_EXEC) begin
      case (ir_opc)
        OPC_ALU_IMM: data_src = DS_IMM;
        OPC_ALU_REG: data_src = DS_REG;
        default:     data_src = DS_MEM;
      endcase
    end
  end

  assign pm_addr   = pc;
  assign immediate = WIDTH'(ir[7:0]);
  assign op        = ir[10:8];
  assign reg_addr  = ir[3:0];
  assign mem_addr  = ir[7:0];
  assign fsm_state = state;

endmodule

// File: tb/tb_ctrl_seq.sv
// tb_ctrl_seq -- directed self-checking bench for ctrl_seq.
// A synchronous ROM model feeds pm_data; every test loads a small program,
// pulses reset and steps through the instruction with hand-computed values.

module tb_ctrl_seq;

  logic        clk;
  logic        rst;
  logic [7:0]  pm_addr;
  logic [15:0] pm_data;
  logic        flag_z, flag_cy, flag_s, flag_o;
  logic [1:0]  data_src;
  logic [7:0]  immediate;
  logic [2:0]  op;
  logic        ce_a, ce_cy;
  logic [3:0]  reg_addr;
  logic        reg_we;
  logic [7:0]  mem_addr;
  logic        mem_we;
  logic        halted, illegal;
  logic [2:0]  fsm_state;

  int n_checks;
  int n_errors;
  int ce_a_edges;
  int base;

  logic [15:0] rom [256];

  ctrl_seq #(.WIDTH(8), .PC_W(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .pm_addr   (pm_addr),
    .pm_data   (pm_data),
    .flag_z    (flag_z),
    .flag_cy   (flag_cy),
    .flag_s    (flag_s),
    .flag_o    (flag_o),
    .data_src  (data_src),
    .immediate (immediate),
    .op        (op),
    .ce_a      (ce_a),
    .ce_cy     (ce_cy),
    .reg_addr  (reg_addr),
    .reg_we    (reg_we),
    .mem_addr  (mem_addr),
    .mem_we    (mem_we),
    .halted    (halted),
    .illegal   (illegal),
    .fsm_state (fsm_state)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // synchronous ROM: data valid one cycle after the address
  always @(posedge clk) pm_data <= rom[pm_addr];

  // accumulator-side view: number of edges at which ce_a was captured high
  initial ce_a_edges = 0;
  always @(posedge clk) if (ce_a === 1'b1) ce_a_edges <= ce_a_edges + 1;

  task automatic check(input string tag, input logic [15:0] got,
                       input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_rom;
    for (int i = 0; i < 256; i++) rom[i] = 16'h0000;
  endtask

  // Reset pulse; releases on a falling edge so the DUT sits in FETCH of
  // address 0 on return.
  task automatic start;
    rst = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    base = ce_a_edges;
  endtask

  function automatic logic [15:0] any_en;
    return {13'd0, ce_a, reg_we, mem_we};
  endfunction

  initial begin
    n_checks = 0;
    n_errors = 0;
    flag_z = 1'b0; flag_cy = 1'b0; flag_s = 1'b0; flag_o = 1'b0;
    rst = 1'b0;
    clear_rom();

    // ---- ALU-imm 0x1005 ----
    rom[0] = 16'h1005;
    start();
    check("rst_pm_addr", 16'(pm_addr), 16'h0000);
    check("rst_state",   16'(fsm_state), 16'd0);
    check("rst_status",  {14'd0, halted, illegal}, 16'd0);
    check("fetch_en",    any_en(), 16'd0);
    step();
    check("decode_en",   any_en(), 16'd0);
    step();
    check("imm_src",     16'(data_src), 16'h0001);
    check("imm_val",     16'(immediate), 16'h0005);
    check("imm_op",      16'(op), 16'h0000);
    check("imm_ce",      {14'd0, ce_a, ce_cy}, 16'h0003);
    step();
    check("imm_after",   {14'd0, ce_a, ce_cy}, 16'h0000);
    check("imm_next_pc", 16'(pm_addr), 16'h0001);
    check("imm_pulses",  16'(ce_a_edges - base), 16'd1);

    // ---- ALU-reg 0x2107 ----
    clear_rom(); rom[0] = 16'h2107;
    start(); step(); step();
    check("reg_src",     16'(data_src), 16'h0003);
    check("reg_addr",    16'(reg_addr), 16'h0007);
    check("reg_op",      16'(op), 16'h0001);
    check("reg_ce",      {14'd0, ce_a, ce_cy}, 16'h0003);

    // ---- ALU-mem 0x3412 ----
    clear_rom(); rom[0] = 16'h3412;
    start(); step(); step();
    check("mem_exec_addr", 16'(mem_addr), 16'h0012);
    check("mem_exec_ce",   16'(ce_a), 16'h0000);
    step();
    check("memrd_src",   16'(data_src), 16'h0000);
    check("memrd_addr",  16'(mem_addr), 16'h0012);
    check("memrd_ce",    {14'd0, ce_a, ce_cy}, 16'h0002);
    step();
    check("mem_next_pc", 16'(pm_addr), 16'h0001);
    check("mem_state",   16'(fsm_state), 16'd0);
    check("mem_pulses",  16'(ce_a_edges - base), 16'd1);

    // ---- ST-reg 0x4003, then ST-mem 0x5033 ----
    clear_rom(); rom[0] = 16'h4003; rom[1] = 16'h5033;
    start(); step(); step();
    check("streg_en",    any_en(), 16'h0002);
    check("streg_addr",  16'(reg_addr), 16'h0003);
    step(); step(); step();
    check("stmem_en",    any_en(), 16'h0001);
    check("stmem_addr",  16'(mem_addr), 16'h0033);

    // ---- JCOND 0x7040 with Z=1 (taken) ----
    clear_rom(); rom[0] = 16'h7040;
    flag_z = 1'b1;
    start(); step(); step(); step();
    check("jz_taken",    16'(pm_addr), 16'h0040);
    // ---- same with Z=0 (not taken) ----
    flag_z = 1'b0;
    start(); step(); step(); step();
    check("jz_not",      16'(pm_addr), 16'h0001);
    // ---- inverted sense 0x7840 with Z=0 (taken) ----
    rom[0] = 16'h7840;
    start(); step(); step(); step();
    check("jnz_taken",   16'(pm_addr), 16'h0040);
    // ---- carry select 0x7140 with CY=1, Z=0 (taken) ----
    rom[0] = 16'h7140;
    flag_cy = 1'b1;
    start(); step(); step(); step();
    check("jc_taken",    16'(pm_addr), 16'h0040);
    flag_cy = 1'b0;

    // ---- JMP to 0xFF then NOP wraps PC to 0x00 ----
    clear_rom(); rom[0] = 16'h60FF;
    start(); step(); step(); step();
    check("jmp_ff",      16'(pm_addr), 16'h00FF);
    step(); step(); step();
    check("pc_wrap",     16'(pm_addr), 16'h0000);

    // ---- illegal 0x8000: sticky, no enables ----
    clear_rom(); rom[0] = 16'h8000;
    start();
    for (int i = 0; i < 3; i++) begin
      check("ill_en", any_en(), 16'd0);
      step();
    end
    check("ill_set",     16'(illegal), 16'h0001);
    repeat (6) step();
    check("ill_sticky",  16'(illegal), 16'h0001);
    check("ill_pc",      16'(pm_addr), 16'h0003);
    check("ill_pulses",  16'(ce_a_edges - base), 16'd0);

    // ---- HALT 0xF000: frozen for 20 cycles ----
    clear_rom(); rom[0] = 16'hF000; rom[1] = 16'h1001;
    start(); step(); step(); step();
    check("halt_set",    16'(halted), 16'h0001);
    check("halt_state",  16'(fsm_state), 16'd4);
    for (int i = 0; i < 20; i++) begin
      check("halt_pc", 16'(pm_addr), 16'h0001);
      check("halt_en", any_en(), 16'd0);
      step();
    end
    start();
    check("halt_cleared", 16'(halted), 16'h0000);

    // ---- reset during MEMRD of 0x3412 aborts without a captured pulse ----
    clear_rom(); rom[0] = 16'h3412;
    start(); step(); step(); step();
    check("abort_in_memrd", 16'(fsm_state), 16'd3);
    base = ce_a_edges;
    rst = 1'b0;
    #1;
    check("abort_ce",    {14'd0, ce_a, ce_cy}, 16'h0000);
    check("abort_state", 16'(fsm_state), 16'd0);
    check("abort_pc",    16'(pm_addr), 16'h0000);
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("abort_pulses", 16'(ce_a_edges - base), 16'd0);
    rst = 1'b1;
    check("restart_pc",  16'(pm_addr), 16'h0000);
    step(); step();
    check("restart_ir_addr", 16'(mem_addr), 16'h0012);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/ctrl_seq.md
CTRL_SEQ -- requirements
Module: ctrl_seq

Interface
REQ-001 SHALL have parameter WIDTH, default 8, datapath width (immediate width).
REQ-002 SHALL have parameter PC_W, default 8, program counter width.
REQ-003 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port pm_addr  output  PC_W  program memory address (registered PC).
REQ-006 SHALL have port pm_data  input  16  program word, valid one cycle after pm_addr (synchronous ROM).
REQ-007 SHALL have port flag_z, flag_cy, flag_s, flag_o  input  1 each  registered flags from the ALU/accumulator stage.
REQ-008 SHALL have port data_src  output  2 (data_src_t)  ALU operand source: 00 mem, 01 imm, 11 reg.
REQ-009 SHALL have port immediate  output  WIDTH  ir[7:0], zero-extended/truncated to WIDTH.
REQ-010 SHALL have port op  output  3  ALU operation, ir[10:8].
REQ-011 SHALL have port ce_a / ce_cy  output  1 each  accumulator / carry clock-enables.
REQ-012 SHALL have port reg_addr  output  4  register index ir[3:0]; reg_we  output  1  register write of accumulator.
REQ-013 SHALL have port mem_addr  output  8  data address ir[7:0]; mem_we  output  1  memory write of accumulator.
REQ-014 SHALL have port halted / illegal  output  1 each  sticky status bits.

Function
REQ-015 SHALL decode ir[15:12]: 0 NOP, 1 ALU-imm, 2 ALU-reg, 3 ALU-mem, 4 ST-reg, 5 ST-mem, 6 JMP ir[7:0], 7 JCOND, F HALT; all other codes are illegal.
REQ-016 SHALL implement states FETCH -> DECODE -> EXEC -> FETCH; ALU-mem inserts MEMRD between EXEC and FETCH; HALT is absorbing.
REQ-017 FETCH: pm_addr = pc; no enables asserted.
REQ-018 DECODE: ir <= pm_data; pc <= pc + 1 modulo 2^PC_W (0xFF wraps to 0x00).
REQ-019 EXEC ALU-imm: data_src=01, ce_a=1 for exactly one cycle.
REQ-020 EXEC ALU-reg: data_src=11, reg_addr=ir[3:0], ce_a=1 for one cycle.
REQ-021 EXEC ALU-mem: mem_addr=ir[7:0], ce_a=0; MEMRD: mem_addr held, data_src=00, ce_a=1 for one cycle (1-cycle RAM latency).
REQ-022 ce_cy SHALL equal ce_a AND (op[2]==0); ce_cy never asserted without ce_a.
REQ-023 EXEC ST-reg: reg_we=1 one cycle; ST-mem: mem_we=1, mem_addr=ir[7:0] one cycle; ce_a=0.
REQ-024 EXEC JMP: pc <= ir[7:0] (truncated/zero-extended to PC_W).
REQ-025 EXEC JCOND: cond = {Z,CY,S,O}[ir[9:8]] XOR ir[11]; taken -> pc <= ir[7:0]; not taken -> pc unchanged.
REQ-026 JCOND SHALL sample flags in EXEC; flags updated by the previous instruction's ce_a edge are visible.
REQ-027 HALT: state -> HALT, halted=1; pc, ir frozen; all enables 0 until reset.
REQ-028 Illegal opcode: executes as NOP, illegal set to 1 and held until reset.
REQ-029 Latency: 3 cycles per instruction, 4 for ALU-mem; jump target fetched in next FETCH.
REQ-030 At most one of ce_a, reg_we, mem_we SHALL be high in any cycle.
REQ-031 data_src, immediate, op, reg_addr, mem_addr SHALL be combinational from ir and state; enables SHALL be 0 in FETCH, DECODE and HALT.

Reset
REQ-032 rst low SHALL immediately force state=FETCH, pc=0, ir=0, halted=0, illegal=0, ce_a=ce_cy=reg_we=mem_we=0, regardless of clock.
REQ-033 Reset asserted mid-instruction (any state, incl. MEMRD) SHALL abort it with no enable pulse; first fetch after release is address 0.

Verification
REQ-034 ROM[0]=0x1005 (ALU-imm op 0, imm 5) -> cycle 3 after reset release: data_src=01, immediate=0x05, op=0, ce_a=1, ce_cy=1, single pulse.
REQ-035 ROM[0]=0x3412 (ALU-mem op 4) -> EXEC: mem_addr=0x12, ce_a=0; MEMRD: data_src=00, ce_a=1, ce_cy=0; next FETCH pm_addr=0x01.
REQ-036 ROM[0]=0x7040 with flag_z=1 -> next pm_addr=0x40; same with flag_z=0 -> pm_addr=0x01; 0x7840 with flag_z=0 -> 0x40.
REQ-037 pc=0xFF holding NOP -> next FETCH pm_addr=0x00; ROM 0x8000 -> illegal=1 sticky, no enables pulsed.
REQ-038 ROM[0]=0xF000 -> halted=1, no further pm_addr change or enables for 20 cycles; rst low during MEMRD of a 0x3xxx -> no ce_a pulse, restart at address 0.
